// File: rtl/nettlp_cmd_pkg.sv
// rtl/nettlp_cmd_pkg.sv - shared types and constants for the NetTLP command sequencer
package nettlp_cmd_pkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  tag;
        logic [15:0] addr;
        logic [31:0] data;
    } FIFO_NETTLP_CMD_T;

    typedef struct packed {
        logic [7:0]  status;
        logic [7:0]  tag;
        logic [15:0] addr;
        logic [31:0] data;
    } NETTLP_RSP_T;

    typedef enum logic [7:0] {
        OP_READ  = 8'h01,
        OP_WRITE = 8'h02,
        OP_PING  = 8'h03
    } NETTLP_CMD_OP_T;

    typedef enum logic [7:0] {
        STS_OK         = 8'h00,
        STS_BAD_OPCODE = 8'h01,
        STS_TIMEOUT    = 8'h02
    } NETTLP_CMD_STS_T;

    localparam logic [31:0] PING_MAGIC = 32'h4E54_4C50;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ACCESS,
        ST_RESP
    } nettlp_cmd_state_t;

endpackage

// File: rtl/nettlp_cmd_timer.sv
// rtl/nettlp_cmd_timer.sv - loadable down-counter that flags expiry on reaching zero
module nettlp_cmd_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/nettlp_cmd_sched.sv
// rtl/nettlp_cmd_sched.sv - pops NetTLP commands, runs register accesses, pushes one response each
module nettlp_cmd_sched
    import nettlp_cmd_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_cmd_i_rd_en,
    input  logic              fifo_cmd_i_empty,
    input  logic [63:0]       fifo_cmd_i_dout,
    output logic              fifo_cmd_o_wr_en,
    input  logic              fifo_cmd_o_full,
    output logic [63:0]       fifo_cmd_o_din,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic              reg_ack,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  cmd_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT_CYCLES - 1);

    nettlp_cmd_state_t state_q, state_d;
    FIFO_NETTLP_CMD_T  cmd_q, cmd_d;
    NETTLP_RSP_T       rsp_q, rsp_d;
    logic              reg_req_q, reg_req_d;
    logic              reg_we_q, reg_we_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic rd_en, wr_en, tmr_load, tmr_en, tmr_expire, op_is_write;

    assign op_is_write = (cmd_q.opcode == OP_WRITE);

    nettlp_cmd_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (TMR_INIT),
        .en_i       (tmr_en),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        rsp_d       = rsp_q;
        reg_req_d   = reg_req_q;
        reg_we_d    = reg_we_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        cmd_cnt_d   = cmd_cnt_q;
        err_cnt_d   = err_cnt_q;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_cmd_i_empty) begin
                    rd_en   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                cmd_d   = fifo_cmd_i_dout;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                rsp_d.tag  = cmd_q.tag;
                rsp_d.addr = cmd_q.addr;
                case (cmd_q.opcode)
                    OP_READ, OP_WRITE: begin
                        reg_req_d   = 1'b1;
                        reg_we_d    = op_is_write;
                        reg_addr_d  = ADDR_W'(cmd_q.addr);
                        reg_wdata_d = op_is_write ? DATA_W'(cmd_q.data) : '0;
                        tmr_load    = 1'b1;
                        state_d     = ST_ACCESS;
                    end
                    OP_PING: begin
                        rsp_d.status = STS_OK;
                        rsp_d.data   = PING_MAGIC;
                        state_d      = ST_RESP;
                    end
                    default: begin
                        rsp_d.status = STS_BAD_OPCODE;
                        rsp_d.data   = '0;
                        state_d      = ST_RESP;
                    end
                endcase
            end
            ST_ACCESS: begin
                tmr_en = 1'b1;
                // ack wins over an expiry landing in the same cycle
                if (reg_ack) begin
                    reg_req_d    = 1'b0;
                    rsp_d.status = STS_OK;
                    rsp_d.data   = reg_we_q ? cmd_q.data : 32'(reg_rdata);
                    state_d      = ST_RESP;
                end else if (tmr_expire) begin
                    reg_req_d    = 1'b0;
                    rsp_d.status = STS_TIMEOUT;
                    rsp_d.data   = '0;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!fifo_cmd_o_full) begin
                    wr_en = 1'b1;
                    if (cmd_cnt_q != '1) cmd_cnt_d = cmd_cnt_q + 1'b1;
                    if ((rsp_q.status != STS_OK) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            reg_req_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            cmd_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            reg_req_q   <= reg_req_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            cmd_cnt_q   <= cmd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Strobes are combinational from state, so hold them low while reset is asserted
    assign fifo_cmd_i_rd_en = rd_en && !rst;
    assign fifo_cmd_o_wr_en = wr_en && !rst;
    assign busy             = (state_q != ST_IDLE) && !rst;
    assign fifo_cmd_o_din   = rsp_q;
    assign reg_req          = reg_req_q;
    assign reg_we           = reg_we_q;
    assign reg_addr         = reg_addr_q;
    assign reg_wdata        = reg_wdata_q;
    assign cmd_count        = cmd_cnt_q;
    assign err_count        = err_cnt_q;

endmodule

// File: tb/tb_nettlp_cmd_sched.sv
// tb/tb_nettlp_cmd_sched.sv - randomized self-checking bench for nettlp_cmd_sched
module tb_nettlp_cmd_sched;

    localparam int TO    = 16;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_cmd_i_rd_en;
    logic        fifo_cmd_i_empty;
    logic [63:0] fifo_cmd_i_dout;
    logic        fifo_cmd_o_wr_en;
    logic        fifo_cmd_o_full;
    logic [63:0] fifo_cmd_o_din;
    logic        reg_req, reg_we, reg_ack, busy;
    logic [15:0] reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic [CNT_W-1:0] cmd_count, err_count;

    always #5 clk = ~clk;

    nettlp_cmd_sched #(
        .ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_cmd_i_rd_en (fifo_cmd_i_rd_en),
        .fifo_cmd_i_empty (fifo_cmd_i_empty),
        .fifo_cmd_i_dout  (fifo_cmd_i_dout),
        .fifo_cmd_o_wr_en (fifo_cmd_o_wr_en),
        .fifo_cmd_o_full  (fifo_cmd_o_full),
        .fifo_cmd_o_din   (fifo_cmd_o_din),
        .reg_req          (reg_req),
        .reg_we           (reg_we),
        .reg_addr         (reg_addr),
        .reg_wdata        (reg_wdata),
        .reg_ack          (reg_ack),
        .reg_rdata        (reg_rdata),
        .busy             (busy),
        .cmd_count        (cmd_count),
        .err_count        (err_count)
    );

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  tag;
        logic [15:0] addr;
        logic [31:0] data;
        int          delay;
        logic [31:0] rdata;
    } cmd_ent_t;

    cmd_ent_t cmds[$];
    int       fifo_q[$];

    int n_checks = 0, n_errors = 0;
    int cyc = 0, rd_cyc = 0, req_len = 0, cur = 0, n_rsp = 0;
    int m_cmd = 0, m_err = 0, full_mode = 0;
    bit pop_pending = 0, outstanding = 0, full_seen = 0, rst_req = 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_rw(input int i);
        return (cmds[i].op == 8'h01) || (cmds[i].op == 8'h02);
    endfunction

    function automatic bit acked(input int i);
        return (cmds[i].delay >= 1) && (cmds[i].delay <= TO);
    endfunction

    function automatic int exp_len(input int i);
        if (!is_rw(i)) return 0;
        return acked(i) ? cmds[i].delay : TO;
    endfunction

    function automatic logic [63:0] exp_rsp(input int i);
        logic [15:0] hdr;
        hdr = {cmds[i].tag, 8'h00};
        case (cmds[i].op)
            8'h01:   return acked(i) ? {8'h00, cmds[i].tag, cmds[i].addr, cmds[i].rdata}
                                     : {8'h02, cmds[i].tag, cmds[i].addr, 32'h0};
            8'h02:   return acked(i) ? {8'h00, cmds[i].tag, cmds[i].addr, cmds[i].data}
                                     : {8'h02, cmds[i].tag, cmds[i].addr, 32'h0};
            8'h03:   return {8'h00, cmds[i].tag, cmds[i].addr, 32'h4E544C50};
            default: return {8'h01, hdr[15:8], cmds[i].addr, 32'h0};
        endcase
    endfunction

    task automatic enqueue(input logic [7:0] op, input logic [7:0] tag, input logic [15:0] addr,
                           input logic [31:0] data, input int delay, input logic [31:0] rdata);
        cmd_ent_t e;
        e.op = op; e.tag = tag; e.addr = addr; e.data = data; e.delay = delay; e.rdata = rdata;
        cmds.push_back(e);
        fifo_q.push_back(cmds.size() - 1);
    endtask

    // One clock: drive inputs at the falling edge, then sample and check 1ns later
    task automatic tick();
        logic [63:0] rsp;
        @(negedge clk);
        rst = rst_req;
        if (pop_pending) begin
            cur = fifo_q.pop_front();
            fifo_cmd_i_dout = {cmds[cur].op, cmds[cur].tag, cmds[cur].addr, cmds[cur].data};
            pop_pending = 0;
        end
        fifo_cmd_i_empty = (fifo_q.size() == 0);
        if (reg_req) begin
            reg_ack   = (cmds[cur].delay == req_len + 1);
            reg_rdata = cmds[cur].rdata;
        end else begin
            reg_ack   = ($urandom_range(3) == 0);
            reg_rdata = $urandom;
        end
        case (full_mode)
            1:       fifo_cmd_o_full = 1'b1;
            2:       fifo_cmd_o_full = ($urandom_range(4) == 0);
            default: fifo_cmd_o_full = 1'b0;
        endcase
        #1;
        cyc++;
        if (!rst) begin
            check_val("cmd_count", cmd_count, m_cmd);
            check_val("err_count", err_count, m_err);
        end
        check_val("rd_wr_same_cycle", fifo_cmd_i_rd_en & fifo_cmd_o_wr_en, 0);
        if (fifo_cmd_o_full) check_val("wr_while_full", fifo_cmd_o_wr_en, 0);
        if (fifo_cmd_i_rd_en) begin
            check_val("pop_with_outstanding", outstanding, 0);
            outstanding = 1; pop_pending = 1; rd_cyc = cyc; full_seen = 0; req_len = 0;
        end
        if (reg_req) begin
            req_len++;
            check_val("req_for_rw_only", is_rw(cur), 1);
            check_val("reg_we", reg_we, cmds[cur].op == 8'h02);
            check_val("reg_addr", reg_addr, cmds[cur].addr);
            if (cmds[cur].op == 8'h02) check_val("reg_wdata", reg_wdata, cmds[cur].data);
        end
        if (fifo_cmd_o_full && outstanding) full_seen = 1;
        if (fifo_cmd_o_wr_en) begin
            rsp = exp_rsp(cur);
            check_val("push_outstanding", outstanding, 1);
            check_val("rsp_word", fifo_cmd_o_din, rsp);
            check_val("req_len", req_len, exp_len(cur));
            if (!full_seen) check_val("latency", cyc - rd_cyc, 3 + exp_len(cur));
            outstanding = 0;
            n_rsp++;
            if (m_cmd < CMAX) m_cmd++;
            if ((rsp[63:56] != 8'h00) && (m_err < CMAX)) m_err++;
        end
    endtask

    task automatic run_until(input int target, input int budget);
        int b;
        b = 0;
        while ((n_rsp < target) && (b < budget)) begin
            tick();
            b++;
        end
        check_val("responses_within_budget", n_rsp, target);
    endtask

    task automatic rand_cmd();
        logic [7:0] op;
        int r;
        r = $urandom_range(0, 9);
        if (r <= 2)      op = 8'h01;
        else if (r <= 5) op = 8'h02;
        else if (r <= 7) op = 8'h03;
        else if (r == 8) op = 8'h00;
        else             op = 8'($urandom_range(4, 255));
        enqueue(op, 8'($urandom), 16'($urandom), $urandom, $urandom_range(0, 20), $urandom);
    endtask

    initial begin
        int b;
        rst = 1'b1; fifo_cmd_i_empty = 1'b1; fifo_cmd_i_dout = '0; fifo_cmd_o_full = 1'b0;
        reg_ack = 1'b0; reg_rdata = '0;
        repeat (3) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_rd_en", fifo_cmd_i_rd_en, 0);
        check_val("rst_wr_en", fifo_cmd_o_wr_en, 0);
        check_val("rst_reg_req", reg_req, 0);
        check_val("rst_reg_addr", reg_addr, 0);
        check_val("rst_din", fifo_cmd_o_din, 0);
        check_val("rst_cmd_count", cmd_count, 0);
        check_val("rst_err_count", err_count, 0);
        rst_req = 0;
        tick();

        enqueue(8'h02, 8'h11, 16'h0010, 32'hDEADBEEF, 3, 32'h0);
        run_until(n_rsp + 1, 100);
        enqueue(8'h01, 8'h22, 16'h0020, 32'h0, 1, 32'h12345678);
        run_until(n_rsp + 1, 100);
        enqueue(8'h01, 8'h33, 16'h0030, 32'h0, 0, 32'hAAAA5555);
        run_until(n_rsp + 1, 100);
        enqueue(8'h01, 8'h34, 16'h0031, 32'h0, TO, 32'h0BADF00D);
        run_until(n_rsp + 1, 100);
        enqueue(8'h7F, 8'h44, 16'h0040, 32'h01020304, 1, 32'h0);
        enqueue(8'h03, 8'h45, 16'h0041, 32'h0, 1, 32'h0);
        run_until(n_rsp + 2, 100);

        full_mode = 1;
        enqueue(8'h03, 8'h55, 16'h0050, 32'h0, 1, 32'h0);
        enqueue(8'h03, 8'h66, 16'h0060, 32'h0, 1, 32'h0);
        b = 0;
        do begin tick(); b++; end while (!fifo_cmd_i_rd_en && b < 20);
        check_val("full_pop_seen", fifo_cmd_i_rd_en, 1);
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            check_val("full_hold_din", fifo_cmd_o_din, exp_rsp(cur));
            check_val("full_hold_wr", fifo_cmd_o_wr_en, 0);
            check_val("full_hold_busy", busy, 1);
            if (i < 9) tick();
        end
        full_mode = 0;
        tick();
        check_val("push_after_full", fifo_cmd_o_wr_en, 1);
        run_until(n_rsp + 1, 100);

        enqueue(8'h01, 8'h77, 16'h0070, 32'h0, 0, 32'h0);
        enqueue(8'h03, 8'h78, 16'h0071, 32'h0, 1, 32'h0);
        b = 0;
        while (!reg_req && b < 20) begin tick(); b++; end
        check_val("access_reached", reg_req, 1);
        repeat (4) tick();
        rst_req = 1;
        tick();
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_wr_en", fifo_cmd_o_wr_en, 0);
        rst_req = 0; outstanding = 0; pop_pending = 0; m_cmd = 0; m_err = 0;
        tick();
        check_val("req_dropped_after_rst", reg_req, 0);
        run_until(n_rsp + 1, 100);

        for (int batch = 0; batch < 8; batch++) begin
            int k;
            k = $urandom_range(1, 8);
            for (int j = 0; j < k; j++) rand_cmd();
            full_mode = 2;
            run_until(n_rsp + k, 1500);
        end
        full_mode = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
